// File: rtl/data_ram_pkg.sv
// ============================================================================
// data_ram_pkg : shared types and helpers for the data RAM controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package data_ram_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Byte offset bits within a word (OFF) and word index bits (AW).
    function automatic int unsigned addr_off(input int unsigned data_w);
        return log2_ceil(data_w / 8);
    endfunction

    function automatic int unsigned addr_aw(input int unsigned depth);
        return log2_ceil(depth);
    endfunction

    // Even parity: stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_bank.sv
// ============================================================================
// data_ram_bank : word storage, one byte-enabled write port, two async reads
// Optional per-byte parity storage when DATA_RAM_PARITY_EN is defined.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module data_ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic [NB-1:0]     wr_en_i,
    input  logic [AW-1:0]     wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
`ifdef DATA_RAM_PARITY_EN
    input  logic [NB-1:0]     wr_par_i,
    output logic [NB-1:0]     rd_par_o,
`endif
    input  logic [AW-1:0]     rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [AW-1:0]     tst_idx_i,
    output logic [DATA_W-1:0] tst_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en_i[i]) begin
                mem_q[wr_idx_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
            end
        end
    end

    assign rd_data_o  = mem_q[rd_idx_i];
    assign tst_data_o = mem_q[tst_idx_i];

`ifdef DATA_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en_i[i]) begin
                par_q[wr_idx_i][i] <= wr_par_i[i];
            end
        end
    end

    assign rd_par_o = par_q[rd_idx_i];
`endif

endmodule

`default_nettype wire

// File: rtl/data_ram_ctrl.sv
// ============================================================================
// data_ram_ctrl : request/response controller around a byte-enabled RAM bank
// Optional macro DATA_RAM_PARITY_EN adds per-byte parity and parity_inject.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_wen,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_perr,
`ifdef DATA_RAM_PARITY_EN
    input  logic                parity_inject,
`endif
    input  logic [31:0]         test_addr,
    output logic [DATA_W-1:0]   test_data,
    output logic                init_done
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = int'(addr_off(DATA_W));
    localparam int AW  = int'(addr_aw(DEPTH));

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_perr_q, rsp_perr_d;
    logic [DATA_W-1:0] test_data_q;

    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     tst_idx;
    logic              req_oor;
    logic [NB-1:0]     wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tst_rdata;
    logic [DATA_W-1:0] merged;
    logic              rd_perr;
    logic              unused_addr_bits;

    assign req_idx = req_addr[OFF+AW-1:OFF];
    assign tst_idx = test_addr[OFF+AW-1:OFF];
    assign req_oor = |req_addr[31:OFF+AW];
    // Byte-offset bits and test_addr high bits are deliberately ignored.
    assign unused_addr_bits = ^{req_addr, test_addr};

`ifdef DATA_RAM_PARITY_EN
    logic [NB-1:0] wr_par;
    logic [NB-1:0] wr_par_req;
    logic [NB-1:0] rd_par;
`endif

    data_ram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NB     (NB)
    ) u_bank (
        .clk        (clk),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_data_i  (wr_data),
`ifdef DATA_RAM_PARITY_EN
        .wr_par_i   (wr_par),
        .rd_par_o   (rd_par),
`endif
        .rd_idx_i   (req_idx),
        .rd_data_o  (rd_data),
        .tst_idx_i  (tst_idx),
        .tst_data_o (tst_rdata)
    );

    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++) begin
            merged[i*8 +: 8] = req_wen[i] ? req_wdata[i*8 +: 8] : rd_data[i*8 +: 8];
        end
    end

`ifdef DATA_RAM_PARITY_EN
    always_comb begin
        wr_par_req = '0;
        rd_perr    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            wr_par_req[i] = byte_parity(merged[i*8 +: 8]) ^ parity_inject;
            rd_perr       = rd_perr | (byte_parity(rd_data[i*8 +: 8]) != rd_par[i]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_perr_d  = rsp_perr_q;
        wr_en       = '0;
        wr_idx      = req_idx;
        wr_data     = merged;
`ifdef DATA_RAM_PARITY_EN
        wr_par      = wr_par_req;
`endif
        case (state_q)
            INIT: begin
                wr_en     = '1;
                wr_idx    = clr_cnt_q;
                wr_data   = '0;
`ifdef DATA_RAM_PARITY_EN
                wr_par    = '0;
`endif
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    if (req_oor) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_perr_d  = 1'b0;
                    end else begin
                        wr_en       = req_wen;
                        rsp_rdata_d = merged;
                        rsp_err_d   = 1'b0;
                        // Parity is only reported for reads of the stored word.
                        rsp_perr_d  = (req_wen == '0) ? rd_perr : 1'b0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_perr_q  <= 1'b0;
            test_data_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_perr_q  <= rsp_perr_d;
            test_data_q <= (state_q == INIT) ? '0 : tst_rdata;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_perr  = rsp_perr_q;
    assign test_data = test_data_q;
    assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// ============================================================================
// tb_data_ram_ctrl : scoreboard bench for data_ram_ctrl (default parameters)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_ram_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_perr;
    logic [31:0] test_addr;
    logic [31:0] test_data;
    logic        init_done;
`ifdef DATA_RAM_PARITY_EN
    logic        parity_inject = 1'b0;
`endif

    always #5 clk = ~clk;

    data_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_perr      (rsp_perr),
`ifdef DATA_RAM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .test_addr     (test_addr),
        .test_data     (test_data),
        .init_done     (init_done)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        perr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    logic [3:0]  bad   [DEPTH];
    int          checks = 0;
    int          errors = 0;

    // Scoreboard: compare every completed response handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h with empty scoreboard want none", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_perr !== e.perr) begin
                    errors++;
                    $display("FAIL rsp got rdata=%h err=%b perr=%b want rdata=%h err=%b perr=%b",
                             rsp_rdata, rsp_err, rsp_perr, e.rdata, e.err, e.perr);
                end
            end
        end
    end

    task automatic send_req(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic inj);
        int          n;
        logic [4:0]  idx;
        logic [31:0] mg;
        exp_t        e;
        n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout got %b want 1", req_ready);
        end
        idx = addr[6:2];
        if (|addr[31:7]) begin
            e.rdata = 32'h0; e.err = 1'b1; e.perr = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mg[i*8 +: 8] = wen[i] ? wdata[i*8 +: 8] : model[idx][i*8 +: 8];
            end
            e.rdata = mg; e.err = 1'b0;
            e.perr  = (wen == 4'h0) ? (|bad[idx]) : 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) bad[idx][i] = inj;
            end
            model[idx] = mg;
        end
        exp_q.push_back(e);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
`ifdef DATA_RAM_PARITY_EN
        parity_inject = inj;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 4'h0;
`ifdef DATA_RAM_PARITY_EN
        parity_inject = 1'b0;
`endif
    endtask

    task automatic accept_rsp();
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_valid_timeout got %b want 1", rsp_valid);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_wen = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; test_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
            rsp_perr !== 1'b0 || test_data !== 32'h0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b rd=%h err=%b perr=%b td=%h done=%b want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr, test_data, init_done);
        end
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 32'h0; bad[i] = 4'h0;
        end
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (init_done === 1'b1 && first < 0) first = k;
            if (k < 32) begin
                checks++;
                if (req_ready !== 1'b0 || init_done !== 1'b0 || test_data !== 32'h0) begin
                    errors++;
                    $display("FAIL init_phase cycle %0d got rdy=%b done=%b td=%h want 0 0 0",
                             k, req_ready, init_done, test_data);
                end
            end
        end
        checks++;
        if (first !== 32) begin
            errors++;
            $display("FAIL init_done_latency got %0d want 32", first);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_init got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        send_req(4'hF, 32'h08, 32'h12345678, 1'b0);
        accept_rsp();
        send_req(4'h1, 32'h08, 32'h000000AB, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h08, 32'h0, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h0B, 32'h0, 1'b0);
        accept_rsp();
    endtask

    task automatic test_backpressure();
        send_req(4'h0, 32'h08, 32'h0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency got %b want 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123456AB || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold got vld=%b rd=%h rdy=%b want 1 123456ab 0",
                         rsp_valid, rsp_rdata, req_ready);
            end
        end
        accept_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_rsp got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_range();
        send_req(4'hF, 32'h04, 32'hCAFEF00D, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h80, 32'h0, 1'b0);
        accept_rsp();
        send_req(4'hF, 32'h100, 32'h55555555, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h00, 32'h0, 1'b0);
        accept_rsp();
        test_addr = 32'h84;
        @(posedge clk); #1;
        checks++;
        if (test_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL test_wrap got %h want cafef00d", test_data);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_w;
        old_w = model[1];
        test_addr = 32'h04;
        send_req(4'hF, 32'h04, 32'hFFFFFFFF, 1'b0);
        checks++;
        if (test_data !== old_w) begin
            errors++;
            $display("FAIL collision_old got %h want %h", test_data, old_w);
        end
        accept_rsp();
        checks++;
        if (test_data !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL collision_new got %h want ffffffff", test_data);
        end
    endtask

`ifdef DATA_RAM_PARITY_EN
    task automatic test_parity();
        send_req(4'hF, 32'h0C, 32'h01020304, 1'b1);
        accept_rsp();
        send_req(4'h0, 32'h0C, 32'h0, 1'b0);
        accept_rsp();
        send_req(4'h1, 32'h0C, 32'h000000EE, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h0C, 32'h0, 1'b0);
        accept_rsp();
        send_req(4'hF, 32'h0C, 32'h0F0E0D0C, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h0C, 32'h0, 1'b0);
        accept_rsp();
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0]  wen;
        logic [31:0] addr;
        for (int k = 0; k < 24; k++) begin
            wen  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            send_req(wen, addr, $urandom, 1'b0);
            accept_rsp();
        end
    endtask

    task automatic test_mid_reset();
        send_req(4'hF, 32'h00, 32'hDEADBEEF, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h00, 32'h0, 1'b0);
        reset = 1'b1;
        #2;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_drop got vld=%b rd=%h want 0 0", rsp_valid, rsp_rdata);
        end
        test_reset();
        send_req(4'h0, 32'h00, 32'h0, 1'b0);
        accept_rsp();
        send_req(4'h0, 32'h7C, 32'h0, 1'b0);
        accept_rsp();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_range();
        test_collision();
`ifdef DATA_RAM_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
